execute_stage: RTL and testbench

//  Execute stage directly downstream of decode: consumes decoded fields plus register operands,

---
 rtl/mips_pkg.sv | 54 +++++
 rtl/muldiv_unit.sv | 136 +++++++++++++
 rtl/execute_stage.sv | 178 +++++++++++++++++
 tb/tb_execute_stage.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - opcode/funct encodings and multiply/divide state type
// Purpose: shared decode constants and the muldiv FSM state enum for the execute stage.
// Ports: none (package).
package mips_pkg;

   // Primary opcodes
   localparam logic [5:0] OP_SPECIAL = 6'h00;
   localparam logic [5:0] OP_J       = 6'h02;
   localparam logic [5:0] OP_JAL     = 6'h03;
   localparam logic [5:0] OP_BEQ     = 6'h04;
   localparam logic [5:0] OP_BNE     = 6'h05;
   localparam logic [5:0] OP_ADDIU   = 6'h09;
   localparam logic [5:0] OP_SLTI    = 6'h0A;
   localparam logic [5:0] OP_SLTIU   = 6'h0B;
   localparam logic [5:0] OP_ANDI    = 6'h0C;
   localparam logic [5:0] OP_ORI     = 6'h0D;
   localparam logic [5:0] OP_XORI    = 6'h0E;
   localparam logic [5:0] OP_LUI     = 6'h0F;
   localparam logic [5:0] OP_LB      = 6'h20;
   localparam logic [5:0] OP_LH      = 6'h21;
   localparam logic [5:0] OP_LW      = 6'h23;
   localparam logic [5:0] OP_LBU     = 6'h24;
   localparam logic [5:0] OP_LHU     = 6'h25;
   localparam logic [5:0] OP_SB      = 6'h28;
   localparam logic [5:0] OP_SH      = 6'h29;
   localparam logic [5:0] OP_SW      = 6'h2B;

   // SPECIAL funct codes
   localparam logic [5:0] FN_SLL   = 6'h00;
   localparam logic [5:0] FN_SRL   = 6'h02;
   localparam logic [5:0] FN_SRA   = 6'h03;
   localparam logic [5:0] FN_JR    = 6'h08;
   localparam logic [5:0] FN_MFHI  = 6'h10;
   localparam logic [5:0] FN_MFLO  = 6'h12;
   localparam logic [5:0] FN_MULT  = 6'h18;
   localparam logic [5:0] FN_MULTU = 6'h19;
   localparam logic [5:0] FN_DIV   = 6'h1A;
   localparam logic [5:0] FN_DIVU  = 6'h1B;
   localparam logic [5:0] FN_ADDU  = 6'h21;
   localparam logic [5:0] FN_SUBU  = 6'h23;
   localparam logic [5:0] FN_AND   = 6'h24;
   localparam logic [5:0] FN_OR    = 6'h25;
   localparam logic [5:0] FN_XOR   = 6'h26;
   localparam logic [5:0] FN_NOR   = 6'h27;
   localparam logic [5:0] FN_SLT   = 6'h2A;
   localparam logic [5:0] FN_SLTU  = 6'h2B;

   typedef enum logic [1:0] {
      MD_IDLE = 2'd0,
      MD_BUSY = 2'd1,
      MD_DONE = 2'd2
   } md_state_e;

endpackage

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative shift-add multiplier / restoring divider holding HI/LO
// Purpose: one bit per cycle MULT(U)/DIV(U); signed ops run on magnitudes, sign fixed in DONE.
// Build option: EXECUTE_MULDIV_EN enables the unit; otherwise outputs are tied to 0.
// Ports: clk_i, rst_ni (async active-low), en_i (freeze when 0), start_i (accepted op),
//        is_div_i, is_signed_i, op_a_i/op_b_i (rs/rt operands),
//        busy_o (iterating), pending_o (not idle), hi_o/lo_o (HI/LO registers).
module muldiv_unit
   import mips_pkg::*;
#(
   parameter int W          = 32,
   parameter int MULDIV_CYC = 32
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         en_i,
   input  logic         start_i,
   input  logic         is_div_i,
   input  logic         is_signed_i,
   input  logic [W-1:0] op_a_i,
   input  logic [W-1:0] op_b_i,
   output logic         busy_o,
   output logic         pending_o,
   output logic [W-1:0] hi_o,
   output logic [W-1:0] lo_o
);
   localparam int CNT_W = (MULDIV_CYC > 1) ? $clog2(MULDIV_CYC) : 1;

`ifdef EXECUTE_MULDIV_EN
   md_state_e        state_q, state_d;
   logic [CNT_W-1:0] count_q;
   logic [2*W-1:0]   acc_q, acc_step, prod_fix;
   logic [W-1:0]     opb_q, dividend_q, hi_q, lo_q;
   logic [W-1:0]     mag_a, mag_b, quo_fix, rem_fix;
   logic             is_div_q, neg_res_q, neg_rem_q, div0_q;
   logic             last;
   logic [W:0]       add_sum;
   logic [W+1:0]     trial;

   assign mag_a = (is_signed_i && op_a_i[W-1]) ? -op_a_i : op_a_i;
   assign mag_b = (is_signed_i && op_b_i[W-1]) ? -op_b_i : op_b_i;
   assign last  = (count_q == CNT_W'(MULDIV_CYC - 1));

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)   state_q <= MD_IDLE;
      else if (en_i) state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         MD_IDLE: if (start_i) state_d = MD_BUSY;
         MD_BUSY: if (last)    state_d = MD_DONE;
         MD_DONE:              state_d = MD_IDLE;
         default:              state_d = MD_IDLE;
      endcase
   end

   always_comb begin
      busy_o    = (state_q == MD_BUSY);
      pending_o = (state_q != MD_IDLE);
   end

   // acc holds {HI-part, LO-part}: product shifts right, dividend/quotient shifts left.
   always_comb begin
      add_sum  = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opb_q} : '0);
      trial    = {1'b0, acc_q[2*W-1:W-1]} - {2'b0, opb_q};
      if (is_div_q)
         acc_step = trial[W+1] ? {acc_q[2*W-2:0], 1'b0}
                               : {trial[W-1:0], acc_q[W-2:0], 1'b1};
      else
         acc_step = {add_sum, acc_q[W-1:1]};
      prod_fix = neg_res_q ? -acc_q : acc_q;
      quo_fix  = neg_res_q ? -acc_q[W-1:0] : acc_q[W-1:0];
      rem_fix  = neg_rem_q ? -acc_q[2*W-1:W] : acc_q[2*W-1:W];
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         count_q    <= '0;
         acc_q      <= '0;
         opb_q      <= '0;
         dividend_q <= '0;
         is_div_q   <= 1'b0;
         neg_res_q  <= 1'b0;
         neg_rem_q  <= 1'b0;
         div0_q     <= 1'b0;
         hi_q       <= '0;
         lo_q       <= '0;
      end else if (en_i) begin
         case (state_q)
            MD_IDLE: if (start_i) begin
               count_q    <= '0;
               acc_q      <= {{W{1'b0}}, mag_a};
               opb_q      <= mag_b;
               dividend_q <= op_a_i;
               is_div_q   <= is_div_i;
               neg_res_q  <= is_signed_i & (op_a_i[W-1] ^ op_b_i[W-1]);
               neg_rem_q  <= is_signed_i & op_a_i[W-1];
               div0_q     <= (op_b_i == '0);
            end
            MD_BUSY: begin
               count_q <= count_q + CNT_W'(1);
               acc_q   <= acc_step;
            end
            MD_DONE: begin
               if (!is_div_q) begin
                  hi_q <= prod_fix[2*W-1:W];
                  lo_q <= prod_fix[W-1:0];
               end else if (div0_q) begin
                  // Divide by zero is defined, not trapped.
                  hi_q <= dividend_q;
                  lo_q <= '1;
               end else begin
                  hi_q <= rem_fix;
                  lo_q <= quo_fix;
               end
            end
            default: ;
         endcase
      end
   end

   assign hi_o = hi_q;
   assign lo_o = lo_q;
`else
   logic             unused_inputs;
   logic [CNT_W-1:0] unused_cnt;
   assign unused_inputs = ^{clk_i, rst_ni, en_i, start_i, is_div_i, is_signed_i, op_a_i, op_b_i};
   assign unused_cnt    = CNT_W'(MULDIV_CYC - 1);
   assign busy_o        = 1'b0;
   assign pending_o     = 1'b0;
   assign hi_o          = '0;
   assign lo_o          = '0;
`endif

endmodule

// File: rtl/execute_stage.sv
// rtl/execute_stage.sv - execute stage: ALU, branch resolution, result register, stall logic
// Purpose: consumes decoded fields and operands, registers one result per accepted instruction.
// Build option: EXECUTE_MULDIV_EN enables MULT/DIV, HI/LO and the muldiv hazard stall.
// Ports: clock, reset_n (async active-low), enable_execute, valid_in, pc, opcode, func, rs, rt,
//        rd, sa, imm, target, rs_data, rt_data, stall_in -> stall_out, valid_out, alu_result,
//        dest_reg, reg_write, branch_taken, branch_target, muldiv_busy.
module execute_stage
   import mips_pkg::*;
#(
   parameter int         DATA_W     = 32,
   parameter int         MULDIV_CYC = 32,
   parameter logic [4:0] LINK_REG   = 5'd31
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              enable_execute,
   input  logic              valid_in,
   input  logic [DATA_W-1:0] pc,
   input  logic [5:0]        opcode,
   input  logic [5:0]        func,
   input  logic [4:0]        rs,
   input  logic [4:0]        rt,
   input  logic [4:0]        rd,
   input  logic [4:0]        sa,
   input  logic [15:0]       imm,
   input  logic [25:0]       target,
   input  logic [DATA_W-1:0] rs_data,
   input  logic [DATA_W-1:0] rt_data,
   input  logic              stall_in,
   output logic              stall_out,
   output logic              valid_out,
   output logic [DATA_W-1:0] alu_result,
   output logic [4:0]        dest_reg,
   output logic              reg_write,
   output logic              branch_taken,
   output logic [DATA_W-1:0] branch_target,
   output logic              muldiv_busy
);
   logic [DATA_W-1:0] sext_imm, zext_imm, pc_plus4, hi_val, lo_val;
   logic [DATA_W-1:0] result_d, target_d, result_q, target_q;
   logic [4:0]        dest_d, dest_q;
   logic              wr_d, br_d, md_start_d, wr_q, br_q, valid_q;
   logic              md_pending, md_op, accept;
   logic              unused_rs;

   assign unused_rs = ^rs;
   assign sext_imm  = {{(DATA_W-16){imm[15]}}, imm};
   assign zext_imm  = {{(DATA_W-16){1'b0}}, imm};
   assign pc_plus4  = pc + DATA_W'(4);

   // Ops that touch HI/LO must wait until the unit is fully idle (including DONE).
   assign md_op     = (opcode == OP_SPECIAL) &&
                      (func inside {FN_MFHI, FN_MFLO, FN_MULT, FN_MULTU, FN_DIV, FN_DIVU});
   assign stall_out = stall_in | (valid_in & md_op & md_pending);
   assign accept    = valid_in & enable_execute & ~stall_out;

   always_comb begin
      result_d   = '0;
      target_d   = '0;
      dest_d     = rd;
      wr_d       = 1'b0;
      br_d       = 1'b0;
      md_start_d = 1'b0;
      case (opcode)
         OP_SPECIAL: begin
            wr_d = 1'b1;
            case (func)
               FN_SLL:  result_d = rt_data << sa;
               FN_SRL:  result_d = rt_data >> sa;
               FN_SRA:  result_d = $signed(rt_data) >>> sa;
               FN_ADDU: result_d = rs_data + rt_data;
               FN_SUBU: result_d = rs_data - rt_data;
               FN_AND:  result_d = rs_data & rt_data;
               FN_OR:   result_d = rs_data | rt_data;
               FN_XOR:  result_d = rs_data ^ rt_data;
               FN_NOR:  result_d = ~(rs_data | rt_data);
               FN_SLT:  result_d = {{(DATA_W-1){1'b0}}, ($signed(rs_data) < $signed(rt_data))};
               FN_SLTU: result_d = {{(DATA_W-1){1'b0}}, (rs_data < rt_data)};
               FN_MFHI: result_d = hi_val;
               FN_MFLO: result_d = lo_val;
               FN_JR: begin
                  wr_d     = 1'b0;
                  br_d     = 1'b1;
                  target_d = rs_data;
               end
               FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: begin
                  wr_d       = 1'b0;
                  md_start_d = 1'b1;
               end
               default: wr_d = 1'b0;
            endcase
         end
         OP_J, OP_JAL: begin
            br_d     = 1'b1;
            target_d = {pc_plus4[DATA_W-1:DATA_W-4], target, 2'b00};
            if (opcode == OP_JAL) begin
               result_d = pc_plus4 + DATA_W'(4);
               dest_d   = LINK_REG;
               wr_d     = 1'b1;
            end
         end
         OP_BEQ, OP_BNE: begin
            target_d = pc_plus4 + (sext_imm << 2);
            br_d     = (rs_data == rt_data) ^ (opcode == OP_BNE);
         end
         OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI,
         OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW: begin
            dest_d = rt;
            wr_d   = 1'b1;
            case (opcode)
               OP_SLTI:  result_d = {{(DATA_W-1){1'b0}}, ($signed(rs_data) < $signed(sext_imm))};
               OP_SLTIU: result_d = {{(DATA_W-1){1'b0}}, (rs_data < sext_imm)};
               OP_ANDI:  result_d = rs_data & zext_imm;
               OP_ORI:   result_d = rs_data | zext_imm;
               OP_XORI:  result_d = rs_data ^ zext_imm;
               OP_LUI:   result_d = {imm, {(DATA_W-16){1'b0}}};
               OP_SB, OP_SH, OP_SW: begin
                  result_d = rs_data + sext_imm;
                  wr_d     = 1'b0;
               end
               default:  result_d = rs_data + sext_imm;
            endcase
         end
         default: ;
      endcase
      if (dest_d == 5'd0) wr_d = 1'b0;
   end

   muldiv_unit #(
      .W          (DATA_W),
      .MULDIV_CYC (MULDIV_CYC)
   ) u_muldiv (
      .clk_i       (clock),
      .rst_ni      (reset_n),
      .en_i        (enable_execute),
      .start_i     (accept & md_start_d),
      .is_div_i    (func[1]),
      .is_signed_i (~func[0]),
      .op_a_i      (rs_data),
      .op_b_i      (rt_data),
      .busy_o      (muldiv_busy),
      .pending_o   (md_pending),
      .hi_o        (hi_val),
      .lo_o        (lo_val)
   );

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         valid_q  <= 1'b0;
         result_q <= '0;
         dest_q   <= '0;
         wr_q     <= 1'b0;
         br_q     <= 1'b0;
         target_q <= '0;
      end else if (enable_execute && !stall_in) begin
         valid_q <= accept;
         if (accept) begin
            result_q <= result_d;
            dest_q   <= dest_d;
            wr_q     <= wr_d;
            br_q     <= br_d;
            target_q <= target_d;
         end else begin
            // Bubble: side-effect flags must not repeat.
            wr_q <= 1'b0;
            br_q <= 1'b0;
         end
      end
   end

   assign valid_out     = valid_q;
   assign alu_result    = result_q;
   assign dest_reg      = dest_q;
   assign reg_write     = wr_q;
   assign branch_taken  = br_q;
   assign branch_target = target_q;

endmodule

// File: tb/tb_execute_stage.sv
// tb/tb_execute_stage.sv - directed self-checking bench for execute_stage
module tb_execute_stage;
   import mips_pkg::*;

`ifdef EXECUTE_MULDIV_EN
   localparam bit MD_EN = 1'b1;
`else
   localparam bit MD_EN = 1'b0;
`endif

   logic        clock = 1'b0;
   logic        reset_n, enable_execute, valid_in, stall_in;
   logic [31:0] pc, rs_data, rt_data;
   logic [5:0]  opcode, func;
   logic [4:0]  rs, rt, rd, sa;
   logic [15:0] imm;
   logic [25:0] target;
   logic        stall_out, valid_out, reg_write, branch_taken, muldiv_busy;
   logic [31:0] alu_result, branch_target;
   logic [4:0]  dest_reg;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clock = ~clock;

   execute_stage dut (
      .clock(clock), .reset_n(reset_n), .enable_execute(enable_execute), .valid_in(valid_in),
      .pc(pc), .opcode(opcode), .func(func), .rs(rs), .rt(rt), .rd(rd), .sa(sa), .imm(imm),
      .target(target), .rs_data(rs_data), .rt_data(rt_data), .stall_in(stall_in),
      .stall_out(stall_out), .valid_out(valid_out), .alu_result(alu_result),
      .dest_reg(dest_reg), .reg_write(reg_write), .branch_taken(branch_taken),
      .branch_target(branch_target), .muldiv_busy(muldiv_busy)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic issue(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] t_rt,
                        input logic [4:0] t_rd, input logic [15:0] t_imm,
                        input logic [31:0] a, input logic [31:0] b);
      valid_in = 1'b1; opcode = op; func = fn; rs = 5'd1; rt = t_rt; rd = t_rd;
      imm = t_imm; rs_data = a; rt_data = b;
   endtask

   task automatic exec(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] t_rt,
                       input logic [4:0] t_rd, input logic [15:0] t_imm,
                       input logic [31:0] a, input logic [31:0] b);
      issue(op, fn, t_rt, t_rd, t_imm, a, b);
      tick();
      valid_in = 1'b0;
   endtask

   task automatic wait_md(input string tag);
      int n = 0;
      while (muldiv_busy && n < 100) begin
         n++;
         tick();
      end
      check_eq(tag, 32'(n), 32'd32);
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, missing;
      reset_n = 1'b0; enable_execute = 1'b1; valid_in = 1'b0; stall_in = 1'b0;
      pc = '0; opcode = '0; func = '0; rs = '0; rt = '0; rd = '0; sa = '0;
      imm = '0; target = '0; rs_data = '0; rt_data = '0;
      tick(); tick();
      check_eq("rst_valid", 32'(valid_out), 32'd0);
      check_eq("rst_result", alu_result, 32'd0);
      check_eq("rst_regwr", 32'(reg_write), 32'd0);
      check_eq("rst_taken", 32'(branch_taken), 32'd0);
      check_eq("rst_busy", 32'(muldiv_busy), 32'd0);
      reset_n = 1'b1;

      exec(OP_SPECIAL, FN_ADDU, 5'd7, 5'd3, 16'd0, 32'd5, 32'd7);
      check_eq("addu_res", alu_result, 32'd12);
      check_eq("addu_dest", 32'(dest_reg), 32'd3);
      check_eq("addu_wr", 32'(reg_write), 32'd1);
      check_eq("addu_valid", 32'(valid_out), 32'd1);
      exec(OP_SPECIAL, FN_SLT, 5'd2, 5'd8, 16'd0, 32'hFFFFFFFF, 32'd1);
      check_eq("slt", alu_result, 32'd1);
      exec(OP_SPECIAL, FN_SLTU, 5'd2, 5'd8, 16'd0, 32'hFFFFFFFF, 32'd1);
      check_eq("sltu", alu_result, 32'd0);

      pc = 32'h80020000;
      exec(OP_BEQ, 6'd0, 5'd2, 5'd0, 16'd3, 32'h55, 32'h55);
      check_eq("beq_taken", 32'(branch_taken), 32'd1);
      check_eq("beq_target", branch_target, 32'h80020010);
      check_eq("beq_wr", 32'(reg_write), 32'd0);
      tick();
      check_eq("bubble_valid", 32'(valid_out), 32'd0);
      check_eq("bubble_taken", 32'(branch_taken), 32'd0);
      exec(OP_BNE, 6'd0, 5'd2, 5'd0, 16'd3, 32'h55, 32'h55);
      check_eq("bne_not_taken", 32'(branch_taken), 32'd0);

      sa = 5'd4;
      exec(OP_SPECIAL, FN_SRA, 5'd2, 5'd5, 16'd0, 32'd0, 32'h80000000);
      check_eq("sra", alu_result, 32'hF8000000);
      sa = 5'd0;
      exec(OP_SPECIAL, FN_SUBU, 5'd2, 5'd5, 16'd0, 32'd3, 32'd5);
      check_eq("subu_wrap", alu_result, 32'hFFFFFFFE);
      exec(OP_SPECIAL, FN_NOR, 5'd2, 5'd5, 16'd0, 32'd0, 32'd0);
      check_eq("nor", alu_result, 32'hFFFFFFFF);

      exec(OP_ADDIU, 6'd0, 5'd0, 5'd0, 16'd1, 32'd1, 32'd0);
      check_eq("addiu_r0_wr", 32'(reg_write), 32'd0);
      exec(OP_ADDIU, 6'd0, 5'd4, 5'd0, 16'hFFFF, 32'h10, 32'd0);
      check_eq("addiu_sext", alu_result, 32'h0000000F);
      check_eq("addiu_dest", 32'(dest_reg), 32'd4);
      exec(OP_ORI, 6'd0, 5'd4, 5'd0, 16'h8000, 32'd0, 32'd0);
      check_eq("ori_zext", alu_result, 32'h00008000);
      exec(OP_LUI, 6'd0, 5'd4, 5'd0, 16'h1234, 32'd0, 32'd0);
      check_eq("lui", alu_result, 32'h12340000);
      exec(OP_LW, 6'd0, 5'd9, 5'd0, 16'hFFFC, 32'h1000, 32'd0);
      check_eq("lw_addr", alu_result, 32'h00000FFC);
      check_eq("lw_wr", 32'(reg_write), 32'd1);
      exec(OP_SW, 6'd0, 5'd9, 5'd0, 16'hFFFC, 32'h1000, 32'd0);
      check_eq("sw_wr", 32'(reg_write), 32'd0);

      pc = 32'h00400000; target = 26'h100;
      exec(OP_JAL, 6'd0, 5'd0, 5'd0, 16'd0, 32'd0, 32'd0);
      check_eq("jal_link", alu_result, 32'h00400008);
      check_eq("jal_dest", 32'(dest_reg), 32'd31);
      check_eq("jal_target", branch_target, 32'h00000400);
      check_eq("jal_taken", 32'(branch_taken), 32'd1);
      exec(OP_SPECIAL, FN_JR, 5'd0, 5'd0, 16'd0, 32'h1234, 32'd0);
      check_eq("jr_target", branch_target, 32'h00001234);
      check_eq("jr_wr", 32'(reg_write), 32'd0);
      exec(6'h3F, 6'd0, 5'd2, 5'd3, 16'd0, 32'd1, 32'd1);
      check_eq("unk_valid", 32'(valid_out), 32'd1);
      check_eq("unk_wr", 32'(reg_write), 32'd0);

      exec(OP_SPECIAL, FN_ADDU, 5'd2, 5'd3, 16'd0, 32'd1, 32'd2);
      stall_in = 1'b1;
      issue(OP_SPECIAL, FN_ADDU, 5'd2, 5'd3, 16'd0, 32'd10, 32'd20);
      #1;
      check_eq("stall_out_fwd", 32'(stall_out), 32'd1);
      tick();
      check_eq("stall_hold_res", alu_result, 32'd3);
      check_eq("stall_hold_valid", 32'(valid_out), 32'd1);
      stall_in = 1'b0;
      tick();
      valid_in = 1'b0;
      check_eq("stall_release", alu_result, 32'd30);
      enable_execute = 1'b0;
      exec(OP_SPECIAL, FN_ADDU, 5'd2, 5'd3, 16'd0, 32'd7, 32'd7);
      check_eq("disable_freeze", alu_result, 32'd30);
      enable_execute = 1'b1;

`ifdef EXECUTE_MULDIV_EN
      exec(OP_SPECIAL, FN_MULT, 5'd2, 5'd0, 16'd0, -32'sd3, 32'd7);
      check_eq("mult_busy_start", 32'(muldiv_busy), 32'd1);
      tick();
      issue(OP_SPECIAL, FN_MFLO, 5'd0, 5'd6, 16'd0, 32'd0, 32'd0);
      n = 1; missing = 0;
      while (muldiv_busy && n < 100) begin
         n++;
         if (!stall_out) missing++;
         tick();
      end
      check_eq("mult_busy_cycles", 32'(n), 32'd32);
      check_eq("mflo_held_busy", 32'(missing), 32'd0);
      check_eq("mflo_held_done", 32'(stall_out), 32'd1);
      tick();
      check_eq("mflo_release", 32'(stall_out), 32'd0);
      tick();
      valid_in = 1'b0;
      check_eq("mult_lo", alu_result, 32'hFFFFFFEB);
      check_eq("mflo_wr", 32'(reg_write), 32'd1);
      exec(OP_SPECIAL, FN_MFHI, 5'd0, 5'd6, 16'd0, 32'd0, 32'd0);
      check_eq("mult_hi", alu_result, 32'hFFFFFFFF);

      exec(OP_SPECIAL, FN_DIVU, 5'd2, 5'd0, 16'd0, 32'd7, 32'd0);
      wait_md("divu0_cycles");
      exec(OP_SPECIAL, FN_MFLO, 5'd0, 5'd6, 16'd0, 32'd0, 32'd0);
      check_eq("divu0_lo", alu_result, 32'hFFFFFFFF);
      exec(OP_SPECIAL, FN_MFHI, 5'd0, 5'd6, 16'd0, 32'd0, 32'd0);
      check_eq("divu0_hi", alu_result, 32'd7);

      exec(OP_SPECIAL, FN_DIV, 5'd2, 5'd0, 16'd0, -32'sd7, 32'd2);
      wait_md("div_cycles");
      exec(OP_SPECIAL, FN_MFLO, 5'd0, 5'd6, 16'd0, 32'd0, 32'd0);
      check_eq("div_quot", alu_result, 32'hFFFFFFFD);
      exec(OP_SPECIAL, FN_MFHI, 5'd0, 5'd6, 16'd0, 32'd0, 32'd0);
      check_eq("div_rem", alu_result, 32'hFFFFFFFF);
`else
      exec(OP_SPECIAL, FN_MULT, 5'd2, 5'd0, 16'd0, -32'sd3, 32'd7);
      check_eq("mult_nop_valid", 32'(valid_out), 32'd1);
      check_eq("mult_nop_wr", 32'(reg_write), 32'd0);
      check_eq("mult_nop_busy", 32'(muldiv_busy), 32'd0);
      issue(OP_SPECIAL, FN_MFLO, 5'd0, 5'd6, 16'd0, 32'd0, 32'd0);
      #1;
      check_eq("mflo_no_stall", 32'(stall_out), 32'd0);
      tick();
      valid_in = 1'b0;
      check_eq("mflo_zero", alu_result, 32'd0);
      check_eq("mflo_wr", 32'(reg_write), 32'd1);
`endif

      exec(OP_SPECIAL, FN_MULT, 5'd2, 5'd0, 16'd0, 32'd5, 32'd5);
      exec(OP_SPECIAL, FN_ADDU, 5'd2, 5'd3, 16'd0, 32'd9, 32'd9);
      check_eq("addu_during_md", alu_result, 32'd18);
      tick();
      check_eq("busy_before_reset", 32'(muldiv_busy), 32'(MD_EN));
      reset_n = 1'b0;
      #1;
      check_eq("midrst_valid", 32'(valid_out), 32'd0);
      check_eq("midrst_result", alu_result, 32'd0);
      check_eq("midrst_dest", 32'(dest_reg), 32'd0);
      check_eq("midrst_busy", 32'(muldiv_busy), 32'd0);
      tick();
      reset_n = 1'b1;
      exec(OP_SPECIAL, FN_MFLO, 5'd0, 5'd6, 16'd0, 32'd0, 32'd0);
      check_eq("midrst_lo", alu_result, 32'd0);
      check_eq("midrst_lo_valid", 32'(valid_out), 32'd1);
      exec(OP_SPECIAL, FN_MFHI, 5'd0, 5'd6, 16'd0, 32'd0, 32'd0);
      check_eq("midrst_hi", alu_result, 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
